// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 row scan, 2-flop column sync, press/release debounce; KEYPAD_AUTO_REPEAT_EN adds held-key repeat.
// Latency: key_press fires DEBOUNCE_CYCLES clocks after a one-hot column is seen at row end; no backpressure.
module keypad_scanner #(
    parameter int SCAN_CYCLES     = 4800,
    parameter int DEBOUNCE_CYCLES = 96000
`ifdef KEYPAD_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES   = 480000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_in_n,
    output logic [3:0] row_drive_n,
    output logic [3:0] row_keys,
    output logic [3:0] col_keys,
    output logic       key_valid,
    output logic       key_press
);

    localparam int MAX_SD = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
`ifdef KEYPAD_AUTO_REPEAT_EN
    localparam int MAX_CYCLES = (REPEAT_CYCLES > MAX_SD) ? REPEAT_CYCLES : MAX_SD;
`else
    localparam int MAX_CYCLES = MAX_SD;
`endif
    localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    cand_col, cand_nxt;
    logic [3:0]    row_nxt, row_rot;
    logic [3:0]    sync1, sync2, col_s;
    logic [3:0]    row_keys_nxt, col_keys_nxt;
    logic          valid_nxt, press_nxt;
    logic          col_onehot, cand_hit, rep_fire;

    assign col_s      = ~sync2;
    assign col_onehot = (col_s != 4'b0000) && ((col_s & (col_s - 4'd1)) == 4'b0000);
    assign cand_hit   = |(col_s & cand_col);
    assign row_rot    = {row_drive_n[2:0], row_drive_n[3]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 4'b1111;
            sync2 <= 4'b1111;
        end else begin
            sync1 <= col_in_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= SCAN;
            cnt         <= '0;
            cand_col    <= 4'b0000;
            row_drive_n <= 4'b1110;
            row_keys    <= 4'b0000;
            col_keys    <= 4'b0000;
            key_valid   <= 1'b0;
            key_press   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cand_col    <= cand_nxt;
            row_drive_n <= row_nxt;
            row_keys    <= row_keys_nxt;
            col_keys    <= col_keys_nxt;
            key_valid   <= valid_nxt;
            key_press   <= press_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        cand_nxt  = cand_col;
        row_nxt   = row_drive_n;
        case (state)
            SCAN: begin
                if (cnt == SCAN_LAST) begin
                    cnt_nxt = '0;
                    if (col_onehot) begin
                        state_nxt = DEBOUNCE;
                        cand_nxt  = col_s;
                    end else begin
                        row_nxt = row_rot;
                    end
                end
            end
            DEBOUNCE: begin
                if (col_s != cand_col) begin
                    state_nxt = SCAN;
                    cnt_nxt   = '0;
                    row_nxt   = row_rot;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end
            end
            HELD: begin
                // Only the accepted column is watched; other keys in the frozen row are ignored.
                cnt_nxt = '0;
                if (!cand_hit) state_nxt = RELEASE;
            end
            RELEASE: begin
                if (cand_hit) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = SCAN;
                    cnt_nxt   = '0;
                    row_nxt   = row_rot;
                end
            end
            default: begin
                state_nxt = SCAN;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        row_keys_nxt = row_keys;
        col_keys_nxt = col_keys;
        valid_nxt    = key_valid;
        press_nxt    = rep_fire;
        if (state == DEBOUNCE && state_nxt == HELD) begin
            row_keys_nxt = ~row_drive_n;
            col_keys_nxt = cand_col;
            valid_nxt    = 1'b1;
            press_nxt    = 1'b1;
        end else if (state == RELEASE && state_nxt == SCAN) begin
            row_keys_nxt = 4'b0000;
            col_keys_nxt = 4'b0000;
            valid_nxt    = 1'b0;
        end
    end

`ifdef KEYPAD_AUTO_REPEAT_EN
    localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
    logic [CW-1:0] rep_cnt;

    assign rep_fire = (state == HELD) && cand_hit && (rep_cnt == REP_LAST);

    // Held at zero outside HELD, so every HELD entry (including from RELEASE) restarts the interval.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_cnt <= '0;
        end else if (state != HELD || rep_fire) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_CYCLES=4, DEBOUNCE_CYCLES=8 (REPEAT_CYCLES=16 when repeat is built in).
module tb_keypad_scanner;

    localparam int SCAN = 4;
    localparam int DEB  = 8;
`ifdef KEYPAD_AUTO_REPEAT_EN
    localparam int REP  = 16;
`endif
    localparam logic [3:0] ROW_SEQ [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  col_in_n;
    logic [3:0]  row_drive_n;
    logic [3:0]  row_keys;
    logic [3:0]  col_keys;
    logic        key_valid;
    logic        key_press;
    logic [15:0] keys;          // keys[r*4+c] = key at row r, column c is closed

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Passive 4x4 matrix: a closed key pulls its column low only while its row is driven low.
    always_comb begin
        col_in_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (!row_drive_n[r]) col_in_n = col_in_n & ~keys[r*4 +: 4];
        end
    end

    keypad_scanner #(
        .SCAN_CYCLES     (SCAN),
        .DEBOUNCE_CYCLES (DEB)
`ifdef KEYPAD_AUTO_REPEAT_EN
        ,
        .REPEAT_CYCLES   (REP)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .col_in_n    (col_in_n),
        .row_drive_n (row_drive_n),
        .row_keys    (row_keys),
        .col_keys    (col_keys),
        .key_valid   (key_valid),
        .key_press   (key_press)
    );

    // Reset is released on a falling edge; the caller's k-th following negedge is k clocks after release.
    task automatic start_from_reset(input logic [15:0] k);
        @(negedge clk);
        reset = 1'b0;
        keys  = k;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        keys  = 16'h0000;
        repeat (3) @(negedge clk);
        n_cmp++; if (row_drive_n !== 4'b1110) begin n_bad++; $display("FAIL reset_row: got %b want 1110", row_drive_n); end
        n_cmp++; if (row_keys !== 4'b0000) begin n_bad++; $display("FAIL reset_row_keys: got %b want 0000", row_keys); end
        n_cmp++; if (col_keys !== 4'b0000) begin n_bad++; $display("FAIL reset_col_keys: got %b want 0000", col_keys); end
        n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", key_valid); end
        n_cmp++; if (key_press !== 1'b0) begin n_bad++; $display("FAIL reset_press: got %b want 0", key_press); end
    endtask

    task automatic test_scan_rotation;
        start_from_reset(16'h0000);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            n_cmp++; if (row_drive_n !== ROW_SEQ[(k / 4) % 4]) begin n_bad++; $display("FAIL scan_row k=%0d: got %b want %b", k, row_drive_n, ROW_SEQ[(k / 4) % 4]); end
            n_cmp++; if (key_press !== 1'b0 || key_valid !== 1'b0) begin n_bad++; $display("FAIL scan_idle k=%0d: got press=%b valid=%b want 0/0", k, key_press, key_valid); end
        end
    endtask

    task automatic test_clean_press;
        int first, count;
        first = 0; count = 0;
        start_from_reset(16'h0200);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (key_press === 1'b1) begin count++; if (first == 0) first = k; end
        end
        n_cmp++; if (first != 20) begin n_bad++; $display("FAIL press_time: got %0d want 20", first); end
        n_cmp++; if (count != 1) begin n_bad++; $display("FAIL press_count: got %0d want 1", count); end
        n_cmp++; if (row_keys !== 4'b0100) begin n_bad++; $display("FAIL press_row_keys: got %b want 0100", row_keys); end
        n_cmp++; if (col_keys !== 4'b0010) begin n_bad++; $display("FAIL press_col_keys: got %b want 0010", col_keys); end
        n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL press_valid: got %b want 1", key_valid); end
        n_cmp++; if (row_drive_n !== 4'b1011) begin n_bad++; $display("FAIL press_row_frozen: got %b want 1011", row_drive_n); end
    endtask

    // Continues from the held row 2 / col 1 key; a 5-clock re-closure lands mid-release.
    task automatic test_release_bounce;
        int count;
        count = 0;
        keys = 16'h0000;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (key_press === 1'b1) count++;
            if (j <= 20) begin
                n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL rel_valid_held j=%0d: got %b want 1", j, key_valid); end
            end
            if (j == 21) begin
                n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL rel_valid_clear: got %b want 0", key_valid); end
                n_cmp++; if (row_keys !== 4'b0000 || col_keys !== 4'b0000) begin n_bad++; $display("FAIL rel_codes_clear: got %b/%b want 0000/0000", row_keys, col_keys); end
                n_cmp++; if (row_drive_n !== 4'b0111) begin n_bad++; $display("FAIL rel_next_row: got %b want 0111", row_drive_n); end
            end
            if (j == 25) begin
                n_cmp++; if (row_drive_n !== 4'b1110) begin n_bad++; $display("FAIL rel_wrap_row: got %b want 1110", row_drive_n); end
            end
            if (j == 5)  keys = 16'h0200;
            if (j == 10) keys = 16'h0000;
        end
        n_cmp++; if (count != 0) begin n_bad++; $display("FAIL rel_no_press: got %0d strobes want 0", count); end
    endtask

    task automatic test_bounce_press;
        int first, count;
        first = 0; count = 0;
        start_from_reset(16'h0008);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (key_press === 1'b1) begin count++; if (first == 0) first = k; end
            keys = (k >= 18 || ((k / 3) % 2) == 0) ? 16'h0008 : 16'h0000;
        end
        n_cmp++; if (first != 30) begin n_bad++; $display("FAIL bounce_time: got %0d want 30", first); end
        n_cmp++; if (count != 1) begin n_bad++; $display("FAIL bounce_count: got %0d want 1", count); end
        n_cmp++; if (row_keys !== 4'b0001 || col_keys !== 4'b1000) begin n_bad++; $display("FAIL bounce_codes: got %b/%b want 0001/1000", row_keys, col_keys); end
    endtask

    task automatic test_multi_key;
        int count;
        count = 0;
        start_from_reset(16'h0030);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (key_press === 1'b1 || key_valid === 1'b1) count++;
        end
        n_cmp++; if (count != 0) begin n_bad++; $display("FAIL multi_no_accept: got %0d active cycles want 0", count); end
        n_cmp++; if (row_drive_n !== 4'b1011) begin n_bad++; $display("FAIL multi_scan_runs: got %b want 1011", row_drive_n); end
    endtask

    task automatic test_second_key_ignored;
        int first, count;
        first = 0; count = 0;
        start_from_reset(16'h0010);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (key_press === 1'b1) begin count++; if (first == 0) first = k; end
            if (k == 25) keys = 16'h1050;
        end
        n_cmp++; if (first != 16) begin n_bad++; $display("FAIL second_time: got %0d want 16", first); end
        n_cmp++; if (count != 1) begin n_bad++; $display("FAIL second_count: got %0d want 1", count); end
        n_cmp++; if (col_keys !== 4'b0001 || row_keys !== 4'b0010) begin n_bad++; $display("FAIL second_codes: got %b/%b want 0010/0001", row_keys, col_keys); end
        n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL second_valid: got %b want 1", key_valid); end
    endtask

    // Entered while the row 1 key is still held; reset lands between clock edges.
    task automatic test_reset_in_held;
        #3 reset = 1'b0;
        #1;
        n_cmp++; if (row_drive_n !== 4'b1110) begin n_bad++; $display("FAIL async_row: got %b want 1110", row_drive_n); end
        n_cmp++; if (row_keys !== 4'b0000 || col_keys !== 4'b0000) begin n_bad++; $display("FAIL async_codes: got %b/%b want 0000/0000", row_keys, col_keys); end
        n_cmp++; if (key_valid !== 1'b0 || key_press !== 1'b0) begin n_bad++; $display("FAIL async_flags: got valid=%b press=%b want 0/0", key_valid, key_press); end
        keys = 16'h0000;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_hold_repeat;
        int count;
        int t [4];
        count = 0;
        for (int i = 0; i < 4; i++) t[i] = 0;
        start_from_reset(16'h0200);
        for (int k = 1; k <= 65; k++) begin
            @(negedge clk);
            if (key_press === 1'b1) begin
                if (count < 4) t[count] = k;
                count++;
            end
        end
        n_cmp++; if (t[0] != 20) begin n_bad++; $display("FAIL hold_first: got %0d want 20", t[0]); end
`ifdef KEYPAD_AUTO_REPEAT_EN
        n_cmp++; if (count != 3) begin n_bad++; $display("FAIL repeat_count: got %0d want 3", count); end
        n_cmp++; if (t[1] != 36) begin n_bad++; $display("FAIL repeat_second: got %0d want 36", t[1]); end
        n_cmp++; if (t[2] != 52) begin n_bad++; $display("FAIL repeat_third: got %0d want 52", t[2]); end
`else
        n_cmp++; if (count != 1) begin n_bad++; $display("FAIL hold_single: got %0d want 1", count); end
`endif
    endtask

    initial begin
        reset = 1'b0;
        keys  = 16'h0000;
        test_reset;
        test_scan_rotation;
        test_clean_press;
        test_release_bounce;
        test_bounce_press;
        test_multi_key;
        test_second_key_ignored;
        test_reset_in_held;
        test_hold_repeat;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
